// File: rtl/spu_fetch_queue_if.sv
// Handshake bundle of the SPU fetch queue: memory fetch port, redirect strobe and issue port.
// The queue connects through the slave modport; its environment (memory + SPU) uses master.
interface spu_fetch_queue_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             fetch_req;
    logic [WIDTH-1:0] fetch_adr;
    logic             fetch_ack;
    logic [WIDTH-1:0] mem_instr0;
    logic [WIDTH-1:0] mem_instr1;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             issue_valid;
    logic             issue_ready;
    logic [WIDTH-1:0] instr0;
    logic [WIDTH-1:0] instr1;
    logic [WIDTH-1:0] issue_pc;
    logic [CW-1:0]    qcount;

    modport slave (
        output fetch_req, fetch_adr, issue_valid, instr0, instr1, issue_pc, qcount,
        input  fetch_ack, mem_instr0, mem_instr1, redirect, redirect_pc, issue_ready
    );

    modport master (
        input  fetch_req, fetch_adr, issue_valid, instr0, instr1, issue_pc, qcount,
        output fetch_ack, mem_instr0, mem_instr1, redirect, redirect_pc, issue_ready
    );
endinterface

// File: rtl/spu_fetch_queue.sv
// Instruction-pair prefetch FIFO for the dual-issue SPU: fetches aligned pairs ahead of
// demand, issues the oldest pair under valid/ready, and flushes/refetches on redirect.

module spu_fetch_queue_chk (
    input logic clk,
    input logic reset,
    input logic push,
    input logic full
);
    push_never_full_a: assert property (@(posedge clk) disable iff (!reset) !(push && full));
endmodule

module spu_fetch_queue #(
    parameter int               WIDTH   = 32,
    parameter int               DEPTH   = 8,
    parameter logic [WIDTH-1:0] RESETPC = {WIDTH{1'b0}}
) (
    input logic              clk,
    input logic              reset,
    spu_fetch_queue_if.slave bus
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [WIDTH-1:0] STEP   = WIDTH'(2'd2);
    localparam logic [WIDTH-1:0] EVEN_MASK = ~(WIDTH'(1'b1));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic             fetch_req_r, fetch_req_s;
    logic [WIDTH-1:0] fetch_adr_r, fetch_adr_s;
    logic [WIDTH-1:0] target_r, target_s;
    logic [AW:0]      head_r, head_s, tail_r, tail_s;
    logic [WIDTH-1:0] pc_mem_r [DEPTH];
    logic [WIDTH-1:0] i0_mem_r [DEPTH];
    logic [WIDTH-1:0] i1_mem_r [DEPTH];

    logic             empty_s, full_s, push_s, pop_s;
    logic [AW:0]      count_s, count_after_s;
    logic [WIDTH-1:0] redirect_tgt_s;

    assign count_s        = tail_r - head_r;
    assign empty_s        = (head_r == tail_r);
    assign full_s         = (head_r[AW] != tail_r[AW]) && (head_r[AW-1:0] == tail_r[AW-1:0]);
    // A redirect cancels both the pop and the push of its cycle.
    assign pop_s          = !empty_s && bus.issue_ready && !bus.redirect;
    assign push_s         = (state_r == REQ) && fetch_req_r && bus.fetch_ack && !bus.redirect;
    assign count_after_s  = count_s + (AW + 1)'(push_s) - (AW + 1)'(pop_s);
    assign redirect_tgt_s = bus.redirect_pc & EVEN_MASK;

    // Fetch FSM next state, fetch address, saved redirect target and queue pointers.
    always_comb begin
        state_s     = state_r;
        fetch_adr_s = fetch_adr_r;
        target_s    = target_r;
        head_s      = head_r + (AW + 1)'(pop_s);
        tail_s      = tail_r + (AW + 1)'(push_s);
        if (bus.redirect) begin
            head_s = {(AW + 1){1'b0}};
            tail_s = {(AW + 1){1'b0}};
        end else begin
            head_s = head_s;
        end
        case (state_r)
            IDLE: begin
                if (bus.redirect) begin
                    state_s     = REQ;
                    fetch_adr_s = redirect_tgt_s;
                end else if (!full_s) begin
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (bus.redirect) begin
                    if (bus.fetch_ack) begin
                        state_s     = REQ;
                        fetch_adr_s = redirect_tgt_s;
                    end else begin
                        // Memory still owes us this request: finish it before moving on.
                        state_s  = DRAIN;
                        target_s = redirect_tgt_s;
                    end
                end else if (bus.fetch_ack) begin
                    fetch_adr_s = fetch_adr_r + STEP;
                    state_s     = (count_after_s < FULL_CNT) ? REQ : IDLE;
                end else begin
                    state_s = REQ;
                end
            end
            DRAIN: begin
                if (bus.redirect) begin
                    state_s  = DRAIN;
                    target_s = redirect_tgt_s;
                end else if (bus.fetch_ack) begin
                    state_s     = REQ;
                    fetch_adr_s = target_r;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        fetch_req_s = (state_s != IDLE);
    end

    // Control state and pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            fetch_req_r <= 1'b0;
            fetch_adr_r <= RESETPC;
            target_r    <= {WIDTH{1'b0}};
            head_r      <= {(AW + 1){1'b0}};
            tail_r      <= {(AW + 1){1'b0}};
        end else begin
            state_r     <= state_s;
            fetch_req_r <= fetch_req_s;
            fetch_adr_r <= fetch_adr_s;
            target_r    <= target_s;
            head_r      <= head_s;
            tail_r      <= tail_s;
        end
    end

    // Entry storage; cleared on reset so the head outputs read zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i] <= {WIDTH{1'b0}};
                i0_mem_r[i] <= {WIDTH{1'b0}};
                i1_mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            pc_mem_r[tail_r[AW-1:0]] <= fetch_adr_r;
            i0_mem_r[tail_r[AW-1:0]] <= bus.mem_instr0;
            i1_mem_r[tail_r[AW-1:0]] <= bus.mem_instr1;
        end
    end

    assign bus.fetch_req   = fetch_req_r;
    assign bus.fetch_adr   = fetch_adr_r;
    assign bus.issue_valid = !empty_s;
    assign bus.instr0      = i0_mem_r[head_r[AW-1:0]];
    assign bus.instr1      = i1_mem_r[head_r[AW-1:0]];
    assign bus.issue_pc    = pc_mem_r[head_r[AW-1:0]];
    assign bus.qcount      = count_s;

    spu_fetch_queue_chk u_chk (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .full  (full_s)
    );
endmodule
